// File: rtl/sys_defs.sv
// Shared processor definitions used by the reorder buffer and its neighbours.
//   XLEN              : datapath width
//   N_ROB_ENTRIES     : reorder buffer depth (power of two)
//   SUPERSCALAR_WAYS  : dispatch / complete / retire width
//   ROB_IDX_BITS      : reorder buffer index width
//   ROB_PACKET        : one reorder buffer entry as seen by dispatch and retire
package sys_defs;

   localparam int XLEN             = 32;
   localparam int N_ROB_ENTRIES    = 32;
   localparam int SUPERSCALAR_WAYS = 3;
   localparam int ROB_IDX_BITS     = $clog2(N_ROB_ENTRIES);

   typedef struct packed {
      logic [XLEN-1:0] PC;
      logic [4:0]      ar_idx;
      logic [XLEN-1:0] dest_value;
      logic [XLEN-1:0] read_data;
      logic [XLEN-1:0] target_pc;
      logic            precise_state_enable;
      logic            complete;
   } ROB_PACKET;

endpackage

// File: rtl/rob_thermo_count.sv
// Population count of a thermometer-coded valid vector.
//   vec   : in,  [W-1:0] slot valids (slot i set implies slots below set)
//   count : out, number of set bits, 0..W
module thermo_count #(
   parameter int W = 3
) (
   input  logic [W-1:0]             vec,
   output logic [$clog2(W+1)-1:0]   count
);

   localparam int CW = $clog2(W + 1);

   // A plain popcount keeps the result sane even if a caller breaks the
   // thermometer rule; it is no larger than a priority encoder for small W.
   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/rob.sv
// Circular reorder buffer between dispatch/execute and retire.
//   clock, reset                 : single clock, async active-high reset
//   dispatch_valid/_in           : in-order allocation of up to W entries
//   dispatch_rob_idx             : index each dispatch slot would receive
//   rob_avail, rob_full/_empty   : occupancy status from registered count
//   complete_*                   : per-slot completion writes from the CDB
//   retire_valid                 : number of head entries retired this cycle
//   br_recover_enable            : full flush to an empty buffer
//   retire_rob_in                : oldest W entries presented to retire
module rob
   import sys_defs::ROB_PACKET, sys_defs::XLEN;
#(
   parameter int N_ROB_ENTRIES    = sys_defs::N_ROB_ENTRIES,
   parameter int SUPERSCALAR_WAYS = sys_defs::SUPERSCALAR_WAYS,
   parameter int ROB_IDX_BITS     = $clog2(N_ROB_ENTRIES)
) (
   input  logic                                             clock,
   input  logic                                             reset,
   input  logic      [SUPERSCALAR_WAYS-1:0]                 dispatch_valid,
   input  ROB_PACKET [SUPERSCALAR_WAYS-1:0]                 dispatch_in,
   output logic      [SUPERSCALAR_WAYS-1:0][ROB_IDX_BITS-1:0] dispatch_rob_idx,
   output logic      [$clog2(SUPERSCALAR_WAYS+1)-1:0]       rob_avail,
   output logic                                             rob_full,
   output logic                                             rob_empty,
   input  logic      [SUPERSCALAR_WAYS-1:0]                 complete_valid,
   input  logic      [SUPERSCALAR_WAYS-1:0][ROB_IDX_BITS-1:0] complete_rob_idx,
   input  logic      [SUPERSCALAR_WAYS-1:0][XLEN-1:0]       complete_dest_value,
   input  logic      [SUPERSCALAR_WAYS-1:0][XLEN-1:0]       complete_read_data,
   input  logic      [SUPERSCALAR_WAYS-1:0][XLEN-1:0]       complete_target_pc,
   input  logic      [SUPERSCALAR_WAYS-1:0]                 complete_precise_state_enable,
   input  logic      [SUPERSCALAR_WAYS-1:0]                 retire_valid,
   input  logic                                             br_recover_enable,
   output ROB_PACKET [SUPERSCALAR_WAYS-1:0]                 retire_rob_in
);

   localparam int W       = SUPERSCALAR_WAYS;
   localparam int N       = N_ROB_ENTRIES;
   localparam int CNT_W   = ROB_IDX_BITS + 1;
   localparam int AVAIL_W = $clog2(W + 1);

   ROB_PACKET                entry_q [N];
   ROB_PACKET                entry_d [N];
   logic [N-1:0]             valid_q, valid_d;
   logic [ROB_IDX_BITS-1:0]  head_q, head_d;
   logic [ROB_IDX_BITS-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]         count_q, count_d;

   logic [AVAIL_W-1:0]       n_disp_raw, n_ret_raw;
   logic [AVAIL_W-1:0]       n_disp, n_ret;
   logic [CNT_W-1:0]         free_slots;
   logic [ROB_IDX_BITS-1:0]  rd_idx, wr_idx, cmp_idx, ret_idx;
   ROB_PACKET                rd_pkt;

   thermo_count #(.W(W)) u_disp_cnt (
      .vec   (dispatch_valid),
      .count (n_disp_raw)
   );

   thermo_count #(.W(W)) u_ret_cnt (
      .vec   (retire_valid),
      .count (n_ret_raw)
   );

   // Outputs depend on registered state only.
   always_comb begin
      free_slots = CNT_W'(N) - count_q;
      rob_avail  = (free_slots < CNT_W'(W)) ? AVAIL_W'(free_slots) : AVAIL_W'(W);
      rob_full   = (count_q == CNT_W'(N));
      rob_empty  = (count_q == '0);
      rd_idx     = '0;
      rd_pkt     = '0;
      for (int i = 0; i < W; i++) begin
         rd_idx = head_q + ROB_IDX_BITS'(i);
         rd_pkt = entry_q[rd_idx];
         // Slots past the occupied region may hold stale data; never let
         // retire see them as complete.
         if (CNT_W'(i) >= count_q) begin
            rd_pkt.complete = 1'b0;
         end
         retire_rob_in[i]    = rd_pkt;
         dispatch_rob_idx[i] = tail_q + ROB_IDX_BITS'(i);
      end
   end

   always_comb begin
      n_disp  = (n_disp_raw > rob_avail) ? rob_avail : n_disp_raw;
      n_ret   = (CNT_W'(n_ret_raw) > count_q) ? AVAIL_W'(count_q) : n_ret_raw;

      entry_d = entry_q;
      valid_d = valid_q;
      wr_idx  = '0;
      cmp_idx = '0;
      ret_idx = '0;

      for (int i = 0; i < W; i++) begin
         if (i < int'(n_disp)) begin
            wr_idx                   = tail_q + ROB_IDX_BITS'(i);
            entry_d[wr_idx]          = dispatch_in[i];
            entry_d[wr_idx].complete = 1'b0;
            valid_d[wr_idx]          = 1'b1;
         end
      end

      // Ascending slot order lets the highest slot win on duplicate indices.
      for (int i = 0; i < W; i++) begin
         if (complete_valid[i] && valid_q[complete_rob_idx[i]]) begin
            cmp_idx                               = complete_rob_idx[i];
            entry_d[cmp_idx].complete             = 1'b1;
            entry_d[cmp_idx].dest_value           = complete_dest_value[i];
            entry_d[cmp_idx].read_data            = complete_read_data[i];
            entry_d[cmp_idx].target_pc            = complete_target_pc[i];
            entry_d[cmp_idx].precise_state_enable = complete_precise_state_enable[i];
         end
      end

      for (int i = 0; i < W; i++) begin
         if (i < int'(n_ret)) begin
            ret_idx                   = head_q + ROB_IDX_BITS'(i);
            valid_d[ret_idx]          = 1'b0;
            entry_d[ret_idx].complete = 1'b0;
         end
      end

      head_d  = head_q + ROB_IDX_BITS'(n_ret);
      tail_d  = tail_q + ROB_IDX_BITS'(n_disp);
      count_d = count_q + CNT_W'(n_disp) - CNT_W'(n_ret);

      // Flush discards this cycle's dispatch and completion writes; payload
      // bits are left stale since valid/complete gate every consumer.
      if (br_recover_enable) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         valid_d = '0;
         for (int j = 0; j < N; j++) begin
            entry_d[j]          = entry_q[j];
            entry_d[j].complete = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         entry_q <= '{default: '0};
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entry_q <= entry_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_rob.sv
module tb_rob;
   import sys_defs::*;

   localparam int N  = 32;
   localparam int W  = 3;
   localparam int IW = 5;

   logic                          clock = 1'b0;
   logic                          reset;
   logic      [W-1:0]             dispatch_valid;
   ROB_PACKET [W-1:0]             dispatch_in;
   logic      [W-1:0][IW-1:0]     dispatch_rob_idx;
   logic      [1:0]               rob_avail;
   logic                          rob_full, rob_empty;
   logic      [W-1:0]             complete_valid;
   logic      [W-1:0][IW-1:0]     complete_rob_idx;
   logic      [W-1:0][XLEN-1:0]   complete_dest_value;
   logic      [W-1:0][XLEN-1:0]   complete_read_data;
   logic      [W-1:0][XLEN-1:0]   complete_target_pc;
   logic      [W-1:0]             complete_precise_state_enable;
   logic      [W-1:0]             retire_valid;
   logic                          br_recover_enable;
   ROB_PACKET [W-1:0]             retire_rob_in;

   int checks   = 0;
   int failures = 0;

   // Reference model: program-ordered list of live entries plus head pointer.
   typedef struct {
      int        idx;
      ROB_PACKET pkt;
   } m_ent_t;
   m_ent_t m_q[$];
   int     m_head = 0;

   rob dut (
      .clock                         (clock),
      .reset                         (reset),
      .dispatch_valid                (dispatch_valid),
      .dispatch_in                   (dispatch_in),
      .dispatch_rob_idx              (dispatch_rob_idx),
      .rob_avail                     (rob_avail),
      .rob_full                      (rob_full),
      .rob_empty                     (rob_empty),
      .complete_valid                (complete_valid),
      .complete_rob_idx              (complete_rob_idx),
      .complete_dest_value           (complete_dest_value),
      .complete_read_data            (complete_read_data),
      .complete_target_pc            (complete_target_pc),
      .complete_precise_state_enable (complete_precise_state_enable),
      .retire_valid                  (retire_valid),
      .br_recover_enable             (br_recover_enable),
      .retire_rob_in                 (retire_rob_in)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic ROB_PACKET rand_pkt();
      ROB_PACKET p;
      p.PC                   = $urandom;
      p.ar_idx               = 5'($urandom);
      p.dest_value           = $urandom;
      p.read_data            = $urandom;
      p.target_pc            = $urandom;
      p.precise_state_enable = 1'($urandom);
      p.complete             = 1'($urandom);
      return p;
   endfunction

   function automatic int pop(logic [W-1:0] v);
      int c = 0;
      for (int i = 0; i < W; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic int m_avail();
      int f = N - m_q.size();
      return (f < W) ? f : W;
   endfunction

   function automatic int m_tail();
      return (m_head + m_q.size()) % N;
   endfunction

   task automatic clear_inputs();
      dispatch_valid                = '0;
      dispatch_in                   = '0;
      complete_valid                = '0;
      complete_rob_idx              = '0;
      complete_dest_value           = '0;
      complete_read_data            = '0;
      complete_target_pc            = '0;
      complete_precise_state_enable = '0;
      retire_valid                  = '0;
      br_recover_enable             = 1'b0;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_head = 0;
   endtask

   // Applies the currently driven inputs to the model, as of the next edge.
   task automatic model_step();
      int     n_ret, n_disp, avail0, tail0;
      m_ent_t e;
      if (br_recover_enable) begin
         model_reset();
         return;
      end
      avail0 = m_avail();
      tail0  = m_tail();
      n_ret  = pop(retire_valid);
      if (n_ret > m_q.size()) n_ret = m_q.size();
      for (int r = 0; r < n_ret; r++) begin
         void'(m_q.pop_front());
         m_head = (m_head + 1) % N;
      end
      for (int s = 0; s < W; s++) begin
         if (complete_valid[s]) begin
            for (int k = 0; k < m_q.size(); k++) begin
               if (m_q[k].idx == int'(complete_rob_idx[s])) begin
                  e = m_q[k];
                  e.pkt.complete             = 1'b1;
                  e.pkt.dest_value           = complete_dest_value[s];
                  e.pkt.read_data            = complete_read_data[s];
                  e.pkt.target_pc            = complete_target_pc[s];
                  e.pkt.precise_state_enable = complete_precise_state_enable[s];
                  m_q[k] = e;
               end
            end
         end
      end
      n_disp = pop(dispatch_valid);
      if (n_disp > avail0) n_disp = avail0;
      for (int d = 0; d < n_disp; d++) begin
         e.idx          = (tail0 + d) % N;
         e.pkt          = dispatch_in[d];
         e.pkt.complete = 1'b0;
         m_q.push_back(e);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      clear_inputs();
   endtask

   task automatic set_dispatch(int n);
      dispatch_valid = W'((1 << n) - 1);
      for (int i = 0; i < W; i++) dispatch_in[i] = rand_pkt();
   endtask

   task automatic set_complete_front(int n);
      for (int i = 0; i < n; i++) begin
         complete_valid[i]                = 1'b1;
         complete_rob_idx[i]              = IW'(m_q[i].idx);
         complete_dest_value[i]           = $urandom;
         complete_read_data[i]            = $urandom;
         complete_target_pc[i]            = $urandom;
         complete_precise_state_enable[i] = 1'($urandom);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      model_reset();
      #12;
      checks++;
      if (rob_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %0b want 1", rob_empty); end
      checks++;
      if (rob_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %0b want 0", rob_full); end
      checks++;
      if (rob_avail !== 2'd3) begin failures++; $display("FAIL reset_avail: got %0d want 3", rob_avail); end
      for (int i = 0; i < W; i++) begin
         checks++;
         if (dispatch_rob_idx[i] !== IW'(i)) begin
            failures++; $display("FAIL reset_disp_idx[%0d]: got %0d want %0d", i, dispatch_rob_idx[i], i);
         end
      end
      checks++;
      if (retire_rob_in !== '0) begin failures++; $display("FAIL reset_retire_out: got %h want 0", retire_rob_in); end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_basic();
      set_dispatch(3);
      for (int i = 0; i < W; i++) dispatch_in[i].ar_idx = 5'(i + 1);
      tick();
      for (int i = 0; i < W; i++) begin
         checks++;
         if (retire_rob_in[i].ar_idx !== 5'(i + 1) || retire_rob_in[i].complete !== 1'b0) begin
            failures++;
            $display("FAIL basic_head[%0d]: got ar_idx=%0d complete=%0b want ar_idx=%0d complete=0",
                     i, retire_rob_in[i].ar_idx, retire_rob_in[i].complete, i + 1);
         end
         checks++;
         if (dispatch_rob_idx[i] !== IW'(3 + i)) begin
            failures++; $display("FAIL basic_disp_idx[%0d]: got %0d want %0d", i, dispatch_rob_idx[i], 3 + i);
         end
      end
      checks++;
      if (rob_avail !== 2'd3) begin failures++; $display("FAIL basic_avail: got %0d want 3", rob_avail); end

      complete_valid[0]      = 1'b1;
      complete_rob_idx[0]    = 5'd1;
      complete_dest_value[0] = 32'hAA;
      #1;
      checks++;
      if (retire_rob_in[1].complete !== 1'b0) begin
         failures++; $display("FAIL basic_no_bypass: got complete=%0b want 0", retire_rob_in[1].complete);
      end
      tick();
      checks++;
      if (retire_rob_in[1].complete !== 1'b1 || retire_rob_in[1].dest_value !== 32'hAA) begin
         failures++; $display("FAIL basic_complete1: got complete=%0b dest=%h want 1/aa",
                              retire_rob_in[1].complete, retire_rob_in[1].dest_value);
      end
      complete_valid[0]      = 1'b1;
      complete_rob_idx[0]    = 5'd0;
      complete_dest_value[0] = 32'hBB;
      tick();
      checks++;
      if (retire_rob_in[0].complete !== 1'b1 || retire_rob_in[0].dest_value !== 32'hBB) begin
         failures++; $display("FAIL basic_complete0: got complete=%0b dest=%h want 1/bb",
                              retire_rob_in[0].complete, retire_rob_in[0].dest_value);
      end
      retire_valid = 3'b011;
      tick();
      checks++;
      if (retire_rob_in[0].ar_idx !== 5'd3 || retire_rob_in[0].complete !== 1'b0) begin
         failures++; $display("FAIL basic_retire_head: got ar_idx=%0d complete=%0b want 3/0",
                              retire_rob_in[0].ar_idx, retire_rob_in[0].complete);
      end
      checks++;
      if (rob_empty !== 1'b0 || rob_avail !== 2'd3 || dispatch_rob_idx[0] !== 5'd3) begin
         failures++; $display("FAIL basic_retire_status: got empty=%0b avail=%0d tail=%0d want 0/3/3",
                              rob_empty, rob_avail, dispatch_rob_idx[0]);
      end
   endtask

   // One live entry (index 2). Duplicate index: slot 2 must win; slot 1
   // targets a free entry and must be ignored.
   task automatic test_dup_complete();
      complete_valid         = 3'b111;
      complete_rob_idx[0]    = 5'd2;
      complete_dest_value[0] = 32'h11;
      complete_rob_idx[1]    = 5'd10;
      complete_dest_value[1] = 32'h33;
      complete_rob_idx[2]    = 5'd2;
      complete_dest_value[2] = 32'h22;
      tick();
      checks++;
      if (retire_rob_in[0].complete !== 1'b1 || retire_rob_in[0].dest_value !== 32'h22) begin
         failures++; $display("FAIL dup_highest_wins: got complete=%0b dest=%h want 1/22",
                              retire_rob_in[0].complete, retire_rob_in[0].dest_value);
      end
      checks++;
      if (retire_rob_in[1].complete !== 1'b0) begin
         failures++; $display("FAIL dup_beyond_count: got complete=%0b want 0", retire_rob_in[1].complete);
      end
   endtask

   task automatic test_full();
      while (m_q.size() < N) begin
         set_dispatch(m_avail());
         tick();
      end
      checks++;
      if (rob_full !== 1'b1 || rob_avail !== 2'd0 || rob_empty !== 1'b0) begin
         failures++; $display("FAIL full_status: got full=%0b avail=%0d empty=%0b want 1/0/0",
                              rob_full, rob_avail, rob_empty);
      end
      checks++;
      if (dispatch_rob_idx[0] !== 5'd2) begin
         failures++; $display("FAIL full_tail: got %0d want 2", dispatch_rob_idx[0]);
      end
      set_dispatch(3);
      tick();
      checks++;
      if (dispatch_rob_idx[0] !== 5'd2 || rob_full !== 1'b1) begin
         failures++; $display("FAIL full_drop: got tail=%0d full=%0b want 2/1", dispatch_rob_idx[0], rob_full);
      end
      set_complete_front(3);
      tick();
      retire_valid = 3'b111;
      set_dispatch(3);
      #1;
      checks++;
      if (rob_avail !== 2'd0) begin
         failures++; $display("FAIL full_same_cycle_avail: got %0d want 0", rob_avail);
      end
      tick();
      checks++;
      if (rob_avail !== 2'd3 || rob_full !== 1'b0 || dispatch_rob_idx[0] !== 5'd2) begin
         failures++; $display("FAIL full_after_retire: got avail=%0d full=%0b tail=%0d want 3/0/2",
                              rob_avail, rob_full, dispatch_rob_idx[0]);
      end
      checks++;
      if (retire_rob_in[0] !== m_q[0].pkt) begin
         failures++; $display("FAIL full_new_head: got %h want %h", retire_rob_in[0], m_q[0].pkt);
      end
   endtask

   task automatic test_wrap();
      br_recover_enable = 1'b1;
      tick();
      for (int r = 0; r < 10; r++) begin
         set_dispatch(3);
         tick();
         set_complete_front(3);
         tick();
         retire_valid = 3'b111;
         tick();
      end
      for (int i = 0; i < W; i++) begin
         checks++;
         if (dispatch_rob_idx[i] !== IW'((30 + i) % N)) begin
            failures++; $display("FAIL wrap_disp_idx[%0d]: got %0d want %0d", i, dispatch_rob_idx[i], (30 + i) % N);
         end
      end
      set_dispatch(3);
      tick();
      for (int i = 0; i < W; i++) begin
         checks++;
         if (retire_rob_in[i] !== m_q[i].pkt) begin
            failures++; $display("FAIL wrap_entry[%0d]: got %h want %h", i, retire_rob_in[i], m_q[i].pkt);
         end
      end
      set_complete_front(3);
      tick();
      checks++;
      if (retire_rob_in[0].complete !== 1'b1 || retire_rob_in[1].complete !== 1'b1 ||
          retire_rob_in[2].complete !== 1'b1) begin
         failures++; $display("FAIL wrap_complete: got %0b%0b%0b want 111", retire_rob_in[2].complete,
                              retire_rob_in[1].complete, retire_rob_in[0].complete);
      end
      retire_valid = 3'b111;
      tick();
      checks++;
      if (rob_empty !== 1'b1 || dispatch_rob_idx[0] !== 5'd1) begin
         failures++; $display("FAIL wrap_drain: got empty=%0b head=%0d want 1/1", rob_empty, dispatch_rob_idx[0]);
      end
   endtask

   task automatic test_flush();
      set_dispatch(3);
      tick();
      set_dispatch(2);
      tick();
      br_recover_enable   = 1'b1;
      set_dispatch(3);
      complete_valid[0]   = 1'b1;
      complete_rob_idx[0] = 5'd2;
      tick();
      checks++;
      if (rob_empty !== 1'b1 || rob_avail !== 2'd3) begin
         failures++; $display("FAIL flush_status: got empty=%0b avail=%0d want 1/3", rob_empty, rob_avail);
      end
      for (int i = 0; i < W; i++) begin
         checks++;
         if (dispatch_rob_idx[i] !== IW'(i) || retire_rob_in[i].complete !== 1'b0) begin
            failures++; $display("FAIL flush_slot[%0d]: got idx=%0d complete=%0b want %0d/0",
                                 i, dispatch_rob_idx[i], retire_rob_in[i].complete, i);
         end
      end
      set_dispatch(1);
      tick();
      checks++;
      if (retire_rob_in[0] !== m_q[0].pkt) begin
         failures++; $display("FAIL flush_redispatch: got %h want %h", retire_rob_in[0], m_q[0].pkt);
      end
   endtask

   task automatic test_async_reset();
      set_dispatch(3);
      tick();
      set_dispatch(3);
      tick();
      set_dispatch(1);
      tick();
      set_complete_front(3);
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (rob_empty !== 1'b1 || rob_full !== 1'b0 || rob_avail !== 2'd3) begin
         failures++; $display("FAIL async_reset_status: got empty=%0b full=%0b avail=%0d want 1/0/3",
                              rob_empty, rob_full, rob_avail);
      end
      for (int i = 0; i < W; i++) begin
         checks++;
         if (dispatch_rob_idx[i] !== IW'(i)) begin
            failures++; $display("FAIL async_reset_idx[%0d]: got %0d want %0d", i, dispatch_rob_idx[i], i);
         end
      end
      checks++;
      if (retire_rob_in !== '0) begin failures++; $display("FAIL async_reset_out: got %h want 0", retire_rob_in); end
      model_reset();
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_random();
      int nd, lead, nr;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ($urandom_range(0, 49) == 0) begin
            br_recover_enable = 1'b1;
            set_dispatch($urandom_range(0, W));
         end else begin
            nd = $urandom_range(0, m_avail());
            set_dispatch(nd);
            for (int s = 0; s < W; s++) begin
               if ($urandom_range(0, 1) == 1) begin
                  complete_valid[s] = 1'b1;
                  if (m_q.size() > 0 && $urandom_range(0, 9) != 0)
                     complete_rob_idx[s] = IW'(m_q[$urandom_range(0, m_q.size() - 1)].idx);
                  else
                     complete_rob_idx[s] = IW'($urandom_range(0, N - 1));
                  complete_dest_value[s]           = $urandom;
                  complete_read_data[s]            = $urandom;
                  complete_target_pc[s]            = $urandom;
                  complete_precise_state_enable[s] = 1'($urandom);
               end
            end
            lead = 0;
            while (lead < W && lead < m_q.size() && m_q[lead].pkt.complete) lead++;
            nr = $urandom_range(0, lead);
            retire_valid = W'((1 << nr) - 1);
         end
         tick();
         checks++;
         if (rob_avail !== 2'(m_avail()) || rob_empty !== (m_q.size() == 0) || rob_full !== (m_q.size() == N)) begin
            failures++; $display("FAIL rand_status cyc %0d: got avail=%0d empty=%0b full=%0b want %0d/%0b/%0b",
                                 cyc, rob_avail, rob_empty, rob_full, m_avail(), m_q.size() == 0, m_q.size() == N);
         end
         for (int i = 0; i < W; i++) begin
            checks++;
            if (dispatch_rob_idx[i] !== IW'((m_tail() + i) % N)) begin
               failures++; $display("FAIL rand_disp_idx[%0d] cyc %0d: got %0d want %0d",
                                    i, cyc, dispatch_rob_idx[i], (m_tail() + i) % N);
            end
            checks++;
            if (i < m_q.size()) begin
               if (retire_rob_in[i] !== m_q[i].pkt) begin
                  failures++; $display("FAIL rand_entry[%0d] cyc %0d: got %h want %h",
                                       i, cyc, retire_rob_in[i], m_q[i].pkt);
               end
            end else if (retire_rob_in[i].complete !== 1'b0) begin
               failures++; $display("FAIL rand_unused_complete[%0d] cyc %0d: got 1 want 0", i, cyc);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dup_complete();
      test_full();
      test_wrap();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
